auto_pilot: RTL

AUTO_PILOT -- requirements
Module: auto_pilot

---
 rtl/auto_pilot.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/auto_pilot.sv
// Wall-following autopilot: settles on a stable detector reading, picks a
// direction by hand rule, drives turns/steps and recovers from stalled turns.
module auto_pilot #(
  parameter int HAND         = 0,
  parameter int SETTLE_CYC   = 16,
  parameter int STEP_CYC     = 1000,
  parameter int TURN_TIMEOUT = 256,
  parameter int BACKOFF_CYC  = 64,
  parameter int STUCK_LIMIT  = 3,
  parameter int BARRIER_EN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       moving,
  input  logic       is_turning,
  input  logic [3:0] detector,
  output logic       move_forward,
  output logic       move_backward,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       place_barrier_signal,
  output logic       destroy_barrier_signal
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(STEP_CYC + 1);
  localparam int TW = $clog2(TURN_TIMEOUT + 1);
  localparam int BW = $clog2(BACKOFF_CYC + 1);
  localparam int KW = $clog2(STUCK_LIMIT + 1);

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [FW-1:0] STEP_LAST    = FW'(STEP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_CYC - 1);
  localparam logic [KW-1:0] STUCK_LAST   = KW'(STUCK_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DECIDE,
    TURN_WAIT,
    FORWARD,
    BACKOFF
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [FW-1:0] fwd_cnt;
  logic [TW-1:0] turn_cnt;
  logic [BW-1:0] back_cnt;
  logic [KW-1:0] stuck_cnt;
  logic [2:0]    prev_det;
  logic          back_pending;
  logic          rose;

  logic front_open;
  logic side_open;
  logic other_open;
  logic unused_det_back;

  assign front_open      = ~detector[0];
  assign side_open       = (HAND == 0) ? ~detector[2] : ~detector[1];
  assign other_open      = (HAND == 0) ? ~detector[1] : ~detector[2];
  assign unused_det_back = detector[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      settle_cnt             <= '0;
      fwd_cnt                <= '0;
      turn_cnt               <= '0;
      back_cnt               <= '0;
      stuck_cnt              <= '0;
      prev_det               <= '0;
      back_pending           <= 1'b0;
      rose                   <= 1'b0;
      move_forward           <= 1'b0;
      move_backward          <= 1'b0;
      trigger_turn_left      <= 1'b0;
      trigger_turn_right     <= 1'b0;
      trigger_turn_back      <= 1'b0;
      place_barrier_signal   <= 1'b0;
      destroy_barrier_signal <= 1'b0;
    end else begin
      prev_det               <= detector[2:0];
      trigger_turn_left      <= 1'b0;
      trigger_turn_right     <= 1'b0;
      trigger_turn_back      <= 1'b0;
      place_barrier_signal   <= 1'b0;
      destroy_barrier_signal <= 1'b0;

      if (!enable) begin
        state         <= IDLE;
        move_forward  <= 1'b0;
        move_backward <= 1'b0;
        back_pending  <= 1'b0;
        rose          <= 1'b0;
        settle_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end

          SETTLE: begin
            if (detector[2:0] != prev_det || moving) begin
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state <= DECIDE;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end

          DECIDE: begin
            settle_cnt <= '0;
            if (side_open) begin
              if (HAND == 0) trigger_turn_right <= 1'b1;
              else           trigger_turn_left  <= 1'b1;
              stuck_cnt <= '0;
              turn_cnt  <= '0;
              rose      <= 1'b0;
              state     <= TURN_WAIT;
            end else if (front_open) begin
              stuck_cnt    <= '0;
              fwd_cnt      <= '0;
              move_forward <= 1'b1;
              state        <= FORWARD;
            end else if (other_open) begin
              if (HAND == 0) trigger_turn_left  <= 1'b1;
              else           trigger_turn_right <= 1'b1;
              stuck_cnt <= '0;
              turn_cnt  <= '0;
              rose      <= 1'b0;
              state     <= TURN_WAIT;
            end else if (stuck_cnt == STUCK_LAST) begin
              destroy_barrier_signal <= 1'b1;
              stuck_cnt              <= '0;
              fwd_cnt                <= '0;
              move_forward           <= 1'b1;
              state                  <= FORWARD;
            end else begin
              // With barriers, the turn-back pulse is issued from TURN_WAIT one
              // cycle later so the two pulses never overlap.
              stuck_cnt <= stuck_cnt + KW'(1);
              turn_cnt  <= '0;
              rose      <= 1'b0;
              state     <= TURN_WAIT;
              if (BARRIER_EN != 0) begin
                place_barrier_signal <= 1'b1;
                back_pending         <= 1'b1;
              end else begin
                trigger_turn_back <= 1'b1;
              end
            end
          end

          TURN_WAIT: begin
            if (back_pending) begin
              trigger_turn_back <= 1'b1;
              back_pending      <= 1'b0;
              turn_cnt          <= '0;
            end else if (!rose) begin
              if (is_turning) begin
                rose <= 1'b1;
              end else if (turn_cnt == TIMEOUT_LAST) begin
                back_cnt      <= '0;
                move_backward <= 1'b1;
                state         <= BACKOFF;
              end else begin
                turn_cnt <= turn_cnt + TW'(1);
              end
            end else if (!is_turning) begin
              rose         <= 1'b0;
              fwd_cnt      <= '0;
              move_forward <= 1'b1;
              state        <= FORWARD;
            end
          end

          FORWARD: begin
            if (detector[0] || fwd_cnt == STEP_LAST) begin
              move_forward <= 1'b0;
              settle_cnt   <= '0;
              state        <= SETTLE;
            end else begin
              fwd_cnt <= fwd_cnt + FW'(1);
            end
          end

          BACKOFF: begin
            if (back_cnt == BACKOFF_LAST) begin
              move_backward <= 1'b0;
              settle_cnt    <= '0;
              state         <= SETTLE;
            end else begin
              back_cnt <= back_cnt + BW'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
